// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit, its control FSM and the mfhi/mflo mux.
// Holds op codes, state encodings and the per-operation context latched at start.
package mult_div_unit_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = 5;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // neg_lo: sign of product/quotient; neg_hi: sign of remainder (dividend sign)
   typedef struct packed {
      logic op;
      logic neg_lo;
      logic neg_hi;
      logic dz;
   } ctx_t;

endpackage

// File: rtl/mult_div_unit_sign_magnitude.sv
// Combinational two's-complement conditional negate; with neg = msb it yields |value|.
// Zero latency, no handshake.
module sign_magnitude #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   output logic [W-1:0] result
);

   assign result = neg ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV producing HI/LO: 33 cycles start-to-done (1 for divide by zero).
// start is only honoured in IDLE; requests while busy are dropped, never queued.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   state_t           state;
   state_t           state_next;
   ctx_t             ctx;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             b_zero;

   // opnd: multiplicand for MULT, divisor for DIV.
   // acc_hi/acc_lo: product register for MULT, remainder/quotient for DIV.
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   sign_magnitude #(.W(WIDTH)) u_abs_a (
      .value  (a),
      .neg    (a[WIDTH-1]),
      .result (mag_a)
   );

   sign_magnitude #(.W(WIDTH)) u_abs_b (
      .value  (b),
      .neg    (b[WIDTH-1]),
      .result (mag_b)
   );

   sign_magnitude #(.W(2*WIDTH)) u_fix_prod (
      .value  ({acc_hi, acc_lo}),
      .neg    (ctx.neg_lo),
      .result (prod_fix)
   );

   sign_magnitude #(.W(WIDTH)) u_fix_quo (
      .value  (acc_lo),
      .neg    (ctx.neg_lo),
      .result (quo_fix)
   );

   sign_magnitude #(.W(WIDTH)) u_fix_rem (
      .value  (acc_hi),
      .neg    (ctx.neg_hi),
      .result (rem_fix)
   );

   assign b_zero = (b == '0);
   assign busy   = (state != S_IDLE);

   // One iteration: MULT adds the multiplicand on a set multiplier lsb then shifts
   // the 64-bit accumulator right; DIV shifts the next dividend bit into the
   // remainder and subtracts only when the divisor fits (restoring).
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      if (ctx.op == OP_MULT) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else begin
         step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], div_ge};
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ((op == OP_DIV) && b_zero) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_next = S_FIN;
            end
         end
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctx      <= '0;
         cnt      <= '0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            ctx      <= '{op:     op,
                          neg_lo: a[WIDTH-1] ^ b[WIDTH-1],
                          neg_hi: a[WIDTH-1],
                          dz:     (op == OP_DIV) && b_zero};
            div_zero <= 1'b0;
            cnt      <= '0;
            opnd     <= (op == OP_MULT) ? mag_a : mag_b;
            acc_hi   <= '0;
            acc_lo   <= (op == OP_MULT) ? mag_b : mag_a;
         end
         if (state == S_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
         end
         if (state == S_FIN) begin
            done <= 1'b1;
            if (ctx.dz) begin
               div_zero <= 1'b1;
            end else if (ctx.op == OP_MULT) begin
               {hi, lo} <= prod_fix;
            end else begin
               lo <= quo_fix;
               hi <= rem_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table plus hand sequences, checked through an expectation queue.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic [7:0]  lat;
   } exp_t;

   typedef struct packed {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   exp_t exp_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   vec_t vecs[10];

   mult_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] h, input logic [31:0] l, input logic z);
      vec_t v;
      v.op    = o;
      v.a     = x;
      v.b     = y;
      v.e.hi  = h;
      v.e.lo  = l;
      v.e.dz  = z;
      v.e.lat = z ? 8'd1 : 8'd33;
      return v;
   endfunction

   // Reference built on native 64-bit signed arithmetic.
   function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx;
      longint sy;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.dz  = 1'b0;
      e.lat = 8'd33;
      if (o == OP_MULT) begin
         r    = sx * sy;
         e.hi = r[63:32];
         e.lo = r[31:0];
      end else if (y == 32'd0) begin
         e.hi  = m_hi;
         e.lo  = m_lo;
         e.dz  = 1'b1;
         e.lat = 8'd1;
      end else begin
         r    = sx / sy;
         e.lo = r[31:0];
         r    = sx % sy;
         e.hi = r[31:0];
      end
      return e;
   endfunction

   // Drives one start pulse and queues its expectation; returns at the negedge after E0.
   task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e, input bit now);
      if (!now) @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      exp_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      @(negedge clk);
      start_cyc = cyc;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("dz_cleared_on_start", {31'd0, div_zero}, 32'd0);
   endtask

   // Waits (bounded) for done, then compares against the oldest queued expectation.
   task automatic wait_done(input string name);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      while (!seen && (cyc - start_cyc) < 200) begin
         @(negedge clk);
         seen = done;
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue: got empty expectation queue expected an entry", name);
      end else begin
         e = exp_q.pop_front();
         if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done after %0d cycles", name, e.lat);
         end else begin
            check({name, "_hi"}, hi, e.hi);
            check({name, "_lo"}, lo, e.lo);
            check({name, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
            check({name, "_lat"}, 32'(cyc - start_cyc), {24'd0, e.lat});
            check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = OP_MULT;
      a     = '0;
      b     = '0;

      vecs[0] = mk(OP_MULT, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      vecs[1] = mk(OP_MULT, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      vecs[2] = mk(OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      vecs[3] = mk(OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      vecs[4] = mk(OP_DIV,  32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      vecs[5] = mk(OP_DIV,  32'h451,       32'h20,       32'h00000011, 32'h00000022, 1'b0);
      vecs[6] = mk(OP_DIV,  32'd5,         32'd0,        32'h00000011, 32'h00000022, 1'b1);
      vecs[7] = mk(OP_MULT, 32'h11,        32'h22,       32'h00000000, 32'h00000242, 1'b0);
      vecs[8] = mk(OP_MULT, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      vecs[9] = mk(OP_DIV,  32'h7FFFFFFF,  32'h10,       32'h0000000F, 32'h07FFFFFF, 1'b0);

      repeat (2) @(negedge clk);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0);
         wait_done($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         logic        o;
         logic [31:0] x;
         logic [31:0] y;
         o = 1'($urandom_range(1));
         x = $urandom;
         y = (i == 3) ? 32'd0 : $urandom >> $urandom_range(28);
         issue(o, x, y, model(o, x, y), 1'b0);
         wait_done($sformatf("rnd%0d", i));
      end

      // A DIV-by-zero start while busy must be dropped entirely.
      issue(OP_MULT, 32'd3, 32'd4, model(OP_MULT, 32'd3, 32'd4), 1'b0);
      while ((cyc - start_cyc) < 10) @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      a     = 32'd100;
      b     = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");

      // Start raised in the done cycle is accepted.
      issue(OP_MULT, 32'd5, 32'd6, model(OP_MULT, 32'd5, 32'd6), 1'b1);
      wait_done("start_in_done");

      // Reset mid-operation: outputs clear at once and the pending result is lost.
      issue(OP_MULT, 32'h1234, 32'h5678, model(OP_MULT, 32'h1234, 32'h5678), 1'b0);
      while ((cyc - start_cyc) < 15) @(negedge clk);
      check("mid_op_lo_held", lo, 32'd30);
      reset = 1'b1;
      #1;
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_dz", {31'd0, div_zero}, 32'd0);
      exp_q.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      issue(OP_MULT, 32'd2, 32'd3, model(OP_MULT, 32'd2, 32'd3), 1'b0);
      wait_done("after_reset");
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle signed multiply/divide unit downstream of the register file.
- Consumes the two read-port operands (rs value, rt value) when the control FSM issues MULT or DIV.
- Produces the architectural HI/LO pair, which the mfhi/mflo path then selects back into the register-file write-data mux.
- Iterative: one partial step per clock, 32 steps per operation, with a start/busy/done handshake toward the main control unit.

Parameters:
WIDTH, 32, operand width and width of HI and LO.
CNT_W, 5, iteration counter width (log2 of WIDTH).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
op  input  1  0 = MULT, 1 = DIV; sampled with start.
a  input  WIDTH  operand A (rs value); multiplicand or dividend.
b  input  WIDTH  operand B (rt value); multiplier or divisor.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle completion pulse.
div_zero  output  1  high when the last DIV had b == 0; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, immediate): hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state = IDLE, counter = 0. Reset mid-operation aborts it; no partial result ever reaches hi/lo.
- States: IDLE, RUN, FIN. busy = (state != IDLE). done is a registered output.
- Edge E0 (IDLE and start = 1):
  - Latch op, magnitudes |a| and |b|, and result sign.
  - Clear div_zero; counter = 0.
  - If op = DIV and b == 0: go to FIN with the dz flag set.
  - Otherwise go to RUN.
- RUN: one step per edge.
  - MULT: shift-add on the magnitudes, 64-bit accumulator.
  - DIV: restoring shift-subtract; quotient and remainder registers.
  - Counter increments each step. The edge with counter == WIDTH-1 performs the last step and moves to FIN.
- FIN (one edge):
  - MULT: {hi, lo} = signed 64-bit product (negated if sign(a) != sign(b)).
  - DIV: lo = quotient, truncated toward zero (negated if signs differ); hi = remainder, carrying the sign of the dividend.
  - DIV by zero: hi and lo keep their previous values; div_zero = 1.
  - In all FIN cases: done = 1 for exactly one cycle, state = IDLE.
- Latency:
  - Normal operation: start edge E0, steps at E1..E32, FIN at E33; done and results visible after E33. busy is high from after E0 until after E33.
  - Divide by zero: FIN at E1; done visible after E1.
- start while busy: ignored; not queued; operands not re-latched.
- start in the same cycle that done is high: accepted, since state is IDLE.
- a and b may change after E0 without effect.
- Edge cases:
  - -2^31 / -1: lo = 0x80000000, hi = 0.
  - -2^31 * -2^31: hi = 0x40000000, lo = 0.
- hi and lo change only at the FIN edge or on reset.

Decomposition:
- Shared package (also used by the control FSM and the mfhi/mflo mux):
  - OP_MULT = 1'b0, OP_DIV = 1'b1.
  - State encodings S_IDLE, S_RUN, S_FIN.
  - WIDTH default.
- One sub-module is natural: sign_magnitude (combinational two's-complement abs and conditional negate), instantiated for operand conditioning and result fix-up.
- The iteration datapath and FSM stay in mult_div_unit.

Test Plan:
- Signed multiply: reset, start MULT a = 7, b = 0xFFFFFFFD (-3) -> done pulses 33 cycles after the start edge; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy falls with done.
- Extreme multiply: MULT a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000. Then DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Signed divide: DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIV a = 7, b = 0xFFFFFFFE (-2) -> lo = 0xFFFFFFFD, hi = 1.
- Divide by zero: preload hi = 0x11, lo = 0x22 via MULT 0x11 * ... (e.g. a result of known value), then DIV a = 5, b = 0 -> done one cycle after the start edge, div_zero = 1, hi/lo unchanged. The next accepted start clears div_zero.
- Handshake: start MULT 3 * 4, pulse start with a DIV at cycle 10 -> ignored, result hi = 0, lo = 12 at cycle 33. A start asserted in the done cycle is accepted (busy = 1 next cycle).
- Reset mid-operation: assert reset at step 15 of MULT 0x1234 * 0x5678 -> hi/lo/busy/done/div_zero all 0 immediately. A fresh MULT 2 * 3 then gives lo = 6 after 33 cycles.
